uart_rx_ctrl: RTL

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 22 ++
 rtl/flex_counter.sv | 36 +++
 rtl/uart_rx_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared FSM state type and default frame constants for the
//               UART receive controller.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int CLKS_PER_BIT = 10;
    localparam int DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_CHK = 3'd1,
        RECEIVE   = 3'd2,
        STOP_CHK  = 3'd3,
        LOAD      = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/flex_counter.sv
`default_nettype none
// ============================================================================
// Module      : flex_counter
// Description : Modulo counter running 0 .. rollover_val-1, with synchronous
//               clear and count enable.
// Revision    : 1.0 - initial release
// ============================================================================
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_clear,
    input  logic             i_count_en,
    input  logic [WIDTH-1:0] i_rollover_val,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en) begin
            r_count <= (r_count == i_rollover_val - c_ONE) ? '0 : r_count + c_ONE;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ctrl
// Description : UART receiver: mid-bit sampling, framing/overrun flags and a
//               single-entry holding register with consumer acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
    parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W = $clog2(DATA_BITS + 2);

    localparam logic [CNT_W-1:0] c_ROLLOVER  = CNT_W'(CLKS_PER_BIT);
    // Counter is cleared on the start edge, so mid-bit lands half a bit later.
    localparam logic [CNT_W-1:0] c_MID       = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] c_LAST_DATA = IDX_W'(DATA_BITS);
    localparam logic [IDX_W-1:0] c_IDX_ONE   = IDX_W'(1);

    uart_pkg::rx_state_t r_state;
    uart_pkg::rx_state_t w_next_state;

    logic [1:0]           r_sync;
    logic                 r_prev;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_data_ready;
    logic                 r_framing_error;
    logic                 r_overrun_error;

    logic [CNT_W-1:0]     w_count;
    logic                 w_sync_in;
    logic                 w_start_edge;
    logic                 w_sample;
    logic                 w_cnt_en;
    logic                 w_start_ok;
    logic                 w_shift;
    logic                 w_stop_bad;
    logic                 w_load;

    assign w_sync_in    = r_sync[1];
    assign w_start_edge = (r_state == uart_pkg::IDLE) && !w_sync_in && r_prev;
    assign w_sample     = (w_count == c_MID);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], serial_in};
            r_prev <= w_sync_in;
        end
    end

    flex_counter #(
        .WIDTH (CNT_W)
    ) u_bit_timer (
        .clk            (clk),
        .n_rst          (n_rst),
        .i_clear        (w_start_edge),
        .i_count_en     (w_cnt_en),
        .i_rollover_val (c_ROLLOVER),
        .o_count        (w_count)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= uart_pkg::IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            uart_pkg::IDLE:      if (w_start_edge) w_next_state = uart_pkg::START_CHK;
            uart_pkg::START_CHK: if (w_sample) w_next_state = w_sync_in ? uart_pkg::IDLE : uart_pkg::RECEIVE;
            uart_pkg::RECEIVE:   if (w_sample && (r_bit_idx == c_LAST_DATA)) w_next_state = uart_pkg::STOP_CHK;
            uart_pkg::STOP_CHK:  if (w_sample) w_next_state = w_sync_in ? uart_pkg::LOAD : uart_pkg::IDLE;
            uart_pkg::LOAD:      w_next_state = uart_pkg::IDLE;
            default:             w_next_state = uart_pkg::IDLE;
        endcase
    end

    always_comb begin
        w_cnt_en   = (r_state != uart_pkg::IDLE);
        w_start_ok = (r_state == uart_pkg::START_CHK) && w_sample && !w_sync_in;
        w_shift    = (r_state == uart_pkg::RECEIVE) && w_sample;
        w_stop_bad = (r_state == uart_pkg::STOP_CHK) && w_sample && !w_sync_in;
        w_load     = (r_state == uart_pkg::LOAD);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (w_start_edge) begin
                r_bit_idx <= '0;
            end else if (w_start_ok || w_shift) begin
                r_bit_idx <= r_bit_idx + c_IDX_ONE;
            end
            if (w_shift) begin
                r_shift <= {w_sync_in, r_shift[DATA_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rx_data       <= '0;
            r_data_ready    <= 1'b0;
            r_framing_error <= 1'b0;
            r_overrun_error <= 1'b0;
        end else begin
            // A read landing in the load cycle consumes the old byte, so no overrun.
            if (w_load) begin
                r_rx_data       <= r_shift;
                r_data_ready    <= 1'b1;
                r_overrun_error <= !data_read && (r_overrun_error || r_data_ready);
            end else if (data_read && r_data_ready) begin
                r_data_ready    <= 1'b0;
                r_overrun_error <= 1'b0;
            end
            if (w_start_ok) begin
                r_framing_error <= 1'b0;
            end else if (w_stop_bad) begin
                r_framing_error <= 1'b1;
            end
        end
    end

    assign rx_data       = r_rx_data;
    assign data_ready    = r_data_ready;
    assign framing_error = r_framing_error;
    assign overrun_error = r_overrun_error;

endmodule
`default_nettype wire
